div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 109 ++++++++++
 tb/tb_div_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// 32-bit iterative radix-2 restoring divider, signed/unsigned, with ready/valid handshake.
// One quotient bit per CALC cycle; sign correction is applied combinationally on the outputs.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        div_signed,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;  // dividend magnitude shifts out while quotient bits shift in
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;

    logic        accept;
    logic        s1_neg, s2_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] trial;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (cnt_q == 5'd31) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        accept = (state_q == IDLE) && in_valid && !flush;
        s1_neg = div_signed && src1[31];
        s2_neg = div_signed && src2[31];
        a_mag  = s1_neg ? -src1 : src1;
        b_mag  = s2_neg ? -src2 : src2;
        trial  = {rem_q, quo_q[31]} - {1'b0, dvs_q};

        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;

        if (accept) begin
            cnt_d  = '0;
            quo_d  = a_mag;
            rem_d  = '0;
            dvs_d  = b_mag;
            qneg_d = s1_neg ^ s2_neg;
            rneg_d = s1_neg;
            dz_d   = (src2 == 32'd0);
        end else if (state_q == CALC && !flush) begin
            cnt_d = cnt_q + 5'd1;
            // bit 32 of the trial difference is the borrow: keep the old partial remainder
            if (!trial[32]) begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = {rem_q[30:0], quo_q[31]};
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        quotient  = dz_q ? 32'hFFFF_FFFF : (qneg_q ? -quo_q : quo_q);
        remainder = rneg_q ? -rem_q : rem_q;
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, overflow, flush, output back-pressure and mid-operation reset.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready, div_signed;
    logic [31:0] src1, src2, quotient, remainder;
    logic        out_valid, out_ready;
    int          checks = 0;
    int          errors = 0;

    div_unit dut (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .div_signed(div_signed), .src1(src1), .src2(src2), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one accepting edge, then scramble the inputs.
    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic sg);
        chk("in_ready_before_req", {31'b0, in_ready}, 32'd1);
        src1 = a; src2 = b; div_signed = sg; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        src1 = ~a; src2 = b ^ 32'h5A5A_5A5A; div_signed = ~sg;
    endtask

    // Caller has already done start(); checks the 32-edge latency and results.
    task automatic finish_op(input string tag, input logic [31:0] eq, input logic [31:0] er);
        repeat (31) step();
        chk({tag, "_not_early"}, {31'b0, out_valid}, 32'd0);
        step();
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_quo"}, quotient, eq);
        chk({tag, "_rem"}, remainder, er);
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic sg, input logic [31:0] eq, input logic [31:0] er);
        start(a, b, sg);
        finish_op(tag, eq, er);
        step();
        chk({tag, "_idle_after"}, {30'b0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        logic        seen_valid;
        logic        stable_ok;
        logic [31:0] hq, hr;

        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; div_signed = 1'b0;
        src1 = '0; src2 = '0; out_ready = 1'b1;
        step(); step();
        resetn = 1'b1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_quo", quotient, 32'h0);
        chk("reset_rem", remainder, 32'h0);

        op("u100_7", 32'd100, 32'd7, 1'b0, 32'h0000_000E, 32'h0000_0002);
        op("s_m7_2", 32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        op("s_7_m2", 32'h7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001);
        op("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'h0000_000E, 32'hFFFF_FFFE);
        op("u_dz", 32'h1234, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234);
        op("s_dz", 32'h1234, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234);
        op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0);
        op("u_big", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);

        // Flush at iteration 10: no result may ever appear for that operation.
        start(32'd1000, 32'd3, 1'b0);
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_idle", {30'b0, in_ready, out_valid}, 32'd2);
        seen_valid = 1'b0;
        repeat (40) begin
            step();
            if (out_valid) seen_valid = 1'b1;
        end
        chk("flush_no_result", {31'b0, seen_valid}, 32'd0);

        // Flush beats a simultaneous request.
        src1 = 32'd9; src2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_prio_not_accepted", {31'b0, in_ready}, 32'd1);
        op("u_after_flush", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'h0000_000F);

        // Back-pressure: hold the result for 5 cycles.
        out_ready = 1'b0;
        start(32'd50, 32'd6, 1'b0);
        finish_op("bp", 32'd8, 32'd2);
        hq = quotient; hr = remainder;
        stable_ok = 1'b1;
        repeat (5) begin
            step();
            if (!out_valid || in_ready || quotient !== hq || remainder !== hr) stable_ok = 1'b0;
        end
        chk("bp_stable", {31'b0, stable_ok}, 32'd1);
        chk("bp_quo_held", quotient, 32'd8);
        out_ready = 1'b1;
        step();
        chk("bp_release", {30'b0, in_ready, out_valid}, 32'd2);

        // Reset mid-CALC.
        start(32'd77, 32'd5, 1'b1);
        repeat (10) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("rst_calc_state", {30'b0, in_ready, out_valid}, 32'd2);
        chk("rst_calc_quo", quotient, 32'h0);
        chk("rst_calc_rem", remainder, 32'h0);

        // Reset while in DONE, overriding out_ready=0 and a pending request.
        out_ready = 1'b0;
        start(32'hFFFF_FFF9, 32'h2, 1'b1);
        finish_op("pre_rst_done", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        resetn = 1'b0; in_valid = 1'b1;
        step();
        resetn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        chk("rst_done_state", {30'b0, in_ready, out_valid}, 32'd2);
        chk("rst_done_quo", quotient, 32'h0);

        op("u_final", 32'd100, 32'd7, 1'b0, 32'h0000_000E, 32'h0000_0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
